// File: rtl/dcache_data_array_pkg.sv
// Shared types and defaults for the multi-way D-cache data store.
package dcache_pkg;

   localparam int unsigned DCACHE_OFFSET_BITS = 5;
   localparam int unsigned DCACHE_INDEX_BITS  = 8;
   localparam int unsigned DCACHE_BYTES       = 2 ** DCACHE_OFFSET_BITS;
   localparam int unsigned DCACHE_LINE_BITS   = 8 * DCACHE_BYTES;

   typedef logic [DCACHE_LINE_BITS-1:0] dcache_line_t;
   typedef logic [DCACHE_BYTES-1:0]     dcache_byteena_t;

   // Post-reset zero-clear sequencer states.
   typedef enum logic {CLEAR, READY} dcache_state_t;

endpackage

// File: rtl/dcache_data_array_if.sv
// Read/write bus between the D-cache controller and the data array.
interface dcache_data_array_if
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS        = 2,
   parameter int unsigned INDEX_BITS  = DCACHE_INDEX_BITS,
   parameter int unsigned OFFSET_BITS = DCACHE_OFFSET_BITS
);
   localparam int unsigned BYTES     = 2 ** OFFSET_BITS;
   localparam int unsigned LINE_BITS = 8 * BYTES;

   logic                      ready;
   logic                      rden;
   logic [INDEX_BITS-1:0]     rdaddress;
   logic [WAYS*LINE_BITS-1:0] q;
   logic                      wren;
   logic [WAYS-1:0]           wrway;
   logic [INDEX_BITS-1:0]     wraddress;
   logic [LINE_BITS-1:0]      data;
   logic [BYTES-1:0]          byteena;

   modport master (
      input  ready, q,
      output rden, rdaddress, wren, wrway, wraddress, data, byteena
   );

   modport slave (
      output ready, q,
      input  rden, rdaddress, wren, wrway, wraddress, data, byteena
   );

endinterface

// File: rtl/dcache_data_array_bram.sv
// Single-way line store: byte-enabled write, registered read that holds
// its output until the next read.
module generic_data_bram #(
   parameter int unsigned INDEX_BITS  = 8,
   parameter int unsigned OFFSET_BITS = 5
) (
   input  logic                        clock,
   input  logic                        wren,
   input  logic [INDEX_BITS-1:0]       wraddress,
   input  logic [8*(2**OFFSET_BITS)-1:0] data,
   input  logic [(2**OFFSET_BITS)-1:0] byteena,
   input  logic                        rden,
   input  logic [INDEX_BITS-1:0]       rdaddress,
   output logic [8*(2**OFFSET_BITS)-1:0] q
);
   localparam int unsigned BYTES     = 2 ** OFFSET_BITS;
   localparam int unsigned LINE_BITS = 8 * BYTES;
   localparam int unsigned SETS      = 2 ** INDEX_BITS;

   logic [LINE_BITS-1:0] mem [SETS];
   logic [LINE_BITS-1:0] rd_d, rd_q;

   // Read port returns the pre-write contents on an address collision.
   always_comb begin
      rd_d = rd_q;
      if (rden) begin
         rd_d = mem[rdaddress];
      end
   end

   // Byte-lane write into the array.
   always_ff @(posedge clock) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
         if (wren && byteena[b]) begin
            mem[wraddress][b*8 +: 8] <= data[b*8 +: 8];
         end
      end
   end

   // Read data register.
   always_ff @(posedge clock) begin
      rd_q <= rd_d;
   end

   assign q = rd_q;

endmodule

// File: rtl/dcache_data_array.sv
// Multi-way D-cache data array with write-first forwarding and held-set
// coherence. Optional post-reset zero sweep: define DCACHE_DATA_CLEAR_EN.
module dcache_data_array
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS        = 2,
   parameter int unsigned INDEX_BITS  = DCACHE_INDEX_BITS,
   parameter int unsigned OFFSET_BITS = DCACHE_OFFSET_BITS
) (
   input logic           clock,
   input logic           reset_n,
   dcache_data_array_if.slave bus
);
   localparam int unsigned BYTES     = 2 ** OFFSET_BITS;
   localparam int unsigned LINE_BITS = 8 * BYTES;

   logic                  ready_d, ready_q;
   logic                  accept_rd, accept_wr;
   logic                  clear_wr;
   logic [INDEX_BITS-1:0] clear_addr;

   logic [WAYS-1:0]       ram_we;
   logic [INDEX_BITS-1:0] ram_addr;
   logic [LINE_BITS-1:0]  ram_data;
   logic [BYTES-1:0]      ram_be;
   logic [LINE_BITS-1:0]  ram_q [WAYS];

   logic [INDEX_BITS-1:0] held_addr_d, held_addr_q;
   logic                  held_valid_d, held_valid_q;
   logic [BYTES-1:0]      wr_mask [WAYS];
   logic [BYTES-1:0]      byp_mask_d [WAYS];
   logic [BYTES-1:0]      byp_mask_q [WAYS];
   logic [LINE_BITS-1:0]  byp_data_d [WAYS];
   logic [LINE_BITS-1:0]  byp_data_q [WAYS];

   assign accept_rd = reset_n & ready_q & bus.rden;
   assign accept_wr = reset_n & ready_q & bus.wren;

`ifdef DCACHE_DATA_CLEAR_EN
   localparam logic [INDEX_BITS-1:0] SetLast = '1;

   dcache_state_t         state_d, state_q;
   logic [INDEX_BITS-1:0] clr_cnt_d, clr_cnt_q;

   // Sweep one set per cycle; the final set's write coincides with entering READY.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         if (clr_cnt_q == SetLast) begin
            state_d = READY;
         end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
         end
      end
   end

   // Clear sequencer state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign clear_wr   = reset_n & (state_q == CLEAR);
   assign clear_addr = clr_cnt_q;
   assign ready_d    = (state_d == READY);
`else
   assign clear_wr   = 1'b0;
   assign clear_addr = '0;
   assign ready_d    = 1'b1;
`endif

   // Ready flag; cleared by reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= ready_d;
      end
   end

   assign bus.ready = ready_q;

   // RAM write port: clear sweep owns it until ready.
   always_comb begin
      ram_addr = bus.wraddress;
      ram_data = bus.data;
      ram_be   = bus.byteena;
      ram_we   = accept_wr ? bus.wrway : '0;
      if (clear_wr) begin
         ram_addr = clear_addr;
         ram_data = '0;
         ram_be   = '1;
         ram_we   = '1;
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      generic_data_bram #(
         .INDEX_BITS  (INDEX_BITS),
         .OFFSET_BITS (OFFSET_BITS)
      ) u_bram (
         .clock     (clock),
         .wren      (ram_we[w]),
         .wraddress (ram_addr),
         .data      (ram_data),
         .byteena   (ram_be),
         .rden      (accept_rd),
         .rdaddress (bus.rdaddress),
         .q         (ram_q[w])
      );
   end

   // Per-way byte lanes written this cycle.
   always_comb begin
      for (int unsigned w = 0; w < WAYS; w++) begin
         wr_mask[w] = (accept_wr && bus.wrway[w]) ? bus.byteena : '0;
      end
   end

   // Bypass tracks bytes of the held set the RAM output does not yet reflect.
   always_comb begin
      held_addr_d  = held_addr_q;
      held_valid_d = held_valid_q;
      for (int unsigned w = 0; w < WAYS; w++) begin
         byp_mask_d[w] = byp_mask_q[w];
         byp_data_d[w] = byp_data_q[w];
         if (accept_rd) begin
            // RAM reads old data on a collision, so the new bytes come from here.
            byp_mask_d[w] = (bus.wraddress == bus.rdaddress) ? wr_mask[w] : '0;
            byp_data_d[w] = bus.data;
         end else if (held_valid_q && (bus.wraddress == held_addr_q)) begin
            byp_mask_d[w] = byp_mask_q[w] | wr_mask[w];
            for (int unsigned b = 0; b < BYTES; b++) begin
               if (wr_mask[w][b]) begin
                  byp_data_d[w][b*8 +: 8] = bus.data[b*8 +: 8];
               end
            end
         end
      end
      if (accept_rd) begin
         held_addr_d  = bus.rdaddress;
         held_valid_d = 1'b1;
      end
   end

   // Held-set tracking state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         held_addr_q  <= '0;
         held_valid_q <= 1'b0;
         for (int unsigned w = 0; w < WAYS; w++) begin
            byp_mask_q[w] <= '0;
         end
      end else begin
         held_addr_q  <= held_addr_d;
         held_valid_q <= held_valid_d;
         for (int unsigned w = 0; w < WAYS; w++) begin
            byp_mask_q[w] <= byp_mask_d[w];
         end
      end
   end

   // Bypass data is only meaningful under its mask, so it needs no reset.
   always_ff @(posedge clock) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
         byp_data_q[w] <= byp_data_d[w];
      end
   end

   // Output merge: bypass bytes over RAM bytes, zero until a read is held.
   always_comb begin
      bus.q = '0;
      if (held_valid_q) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
               bus.q[w*LINE_BITS + b*8 +: 8] = byp_mask_q[w][b] ? byp_data_q[w][b*8 +: 8]
                                                                 : ram_q[w][b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dcache_data_array.sv
// Self-checking bench for dcache_data_array against a byte-array model.
module tb_dcache_data_array;
   localparam int unsigned WAYS        = 4;
   localparam int unsigned INDEX_BITS  = 8;
   localparam int unsigned OFFSET_BITS = 5;
   localparam int unsigned BYTES       = 32;
   localparam int unsigned LINE_BITS   = 256;
   localparam int unsigned SETS        = 256;
   localparam int unsigned QW          = WAYS * LINE_BITS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_data_array_if #(
      .WAYS        (WAYS),
      .INDEX_BITS  (INDEX_BITS),
      .OFFSET_BITS (OFFSET_BITS)
   ) bus ();

   dcache_data_array #(
      .WAYS        (WAYS),
      .INDEX_BITS  (INDEX_BITS),
      .OFFSET_BITS (OFFSET_BITS)
   ) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   // Reference model: contents per way/set, the held set, and readiness.
   logic [LINE_BITS-1:0]  mem_m [WAYS][SETS];
   logic [INDEX_BITS-1:0] held_m = '0;
   logic                  hv_m = 1'b0;
   logic                  rdy_m = 1'b0;
   int                    clr_left = 0;

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [LINE_BITS-1:0] rand_line();
      logic [LINE_BITS-1:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [QW-1:0] exp_q();
      logic [QW-1:0] e;
      e = '0;
      if (hv_m) for (int w = 0; w < WAYS; w++) e[w*LINE_BITS +: LINE_BITS] = mem_m[w][held_m];
      return e;
   endfunction

   function automatic int bad_way(logic [QW-1:0] a, logic [QW-1:0] e);
      for (int w = 0; w < WAYS; w++)
         if (a[w*LINE_BITS +: LINE_BITS] !== e[w*LINE_BITS +: LINE_BITS]) return w;
      return 0;
   endfunction

   task automatic idle();
      bus.rden = 1'b0; bus.rdaddress = '0; bus.wren = 1'b0; bus.wrway = '0;
      bus.wraddress = '0; bus.data = '0; bus.byteena = '0;
   endtask

   // Apply this cycle's inputs to the model, then advance one edge.
   task automatic tick();
      if (!rst_n) begin
         hv_m = 1'b0; held_m = '0; rdy_m = 1'b0; clr_left = SETS;
      end else if (!rdy_m) begin
`ifdef DCACHE_DATA_CLEAR_EN
         for (int w = 0; w < WAYS; w++) mem_m[w][SETS - clr_left] = '0;
         clr_left--;
         if (clr_left == 0) rdy_m = 1'b1;
`else
         rdy_m = 1'b1;
`endif
      end else begin
         if (bus.wren)
            for (int w = 0; w < WAYS; w++)
               for (int b = 0; b < BYTES; b++)
                  if (bus.wrway[w] && bus.byteena[b])
                     mem_m[w][bus.wraddress][b*8 +: 8] = bus.data[b*8 +: 8];
         if (bus.rden) begin held_m = bus.rdaddress; hv_m = 1'b1; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [QW-1:0] e;
      int w;
      idle();
      rst_n = 1'b0;
      tick(); tick();
      vectors++;
      if (bus.ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_ready ready=%b expected=0", bus.ready);
      end
      vectors++;
      if (bus.q !== '0) begin
         miscompares++; w = bad_way(bus.q, '0);
         $display("FAIL reset_q way %0d q=%h expected=0", w, bus.q[w*LINE_BITS +: LINE_BITS]);
      end
      rst_n = 1'b1;
      for (int i = 0; i < SETS + 2; i++) begin
         tick();
         vectors++;
         if (bus.ready !== rdy_m) begin
            miscompares++;
            $display("FAIL init_ready cycle %0d ready=%b expected=%b", i + 1, bus.ready, rdy_m);
         end
      end
`ifdef DCACHE_DATA_CLEAR_EN
      bus.rden = 1'b1; bus.rdaddress = 8'd37;
      tick();
      idle();
      e = exp_q();
      vectors++;
      if (bus.q !== '0 || bus.q !== e) begin
         miscompares++; w = bad_way(bus.q, '0);
         $display("FAIL clear_set37 way %0d q=%h expected=0", w, bus.q[w*LINE_BITS +: LINE_BITS]);
      end
`else
      // Contents are undefined without the sweep; give every line a known value.
      for (int s = 0; s < SETS; s++) begin
         bus.wren = 1'b1; bus.wrway = '1; bus.byteena = '1;
         bus.wraddress = s[INDEX_BITS-1:0]; bus.data = rand_line();
         tick();
      end
      idle();
`endif
   endtask

   task automatic test_write_read();
      logic [QW-1:0] e;
      int w;
      bus.wren = 1'b1; bus.wrway = 4'b0010; bus.wraddress = 8'd5;
      bus.data = {32{8'hA5}}; bus.byteena = 32'h0000_000F;
      tick();
      idle();
      bus.rden = 1'b1; bus.rdaddress = 8'd5;
      tick();
      idle();
      e = exp_q();
      vectors++;
      if (bus.q[LINE_BITS +: 32] !== 32'hA5A5_A5A5) begin
         miscompares++;
         $display("FAIL wr_way1_bytes q=%h expected=a5a5a5a5", bus.q[LINE_BITS +: 32]);
      end
      vectors++;
      if (bus.q !== e) begin
         miscompares++; w = bad_way(bus.q, e);
         $display("FAIL wr_then_rd way %0d q=%h expected=%h", w,
                  bus.q[w*LINE_BITS +: LINE_BITS], e[w*LINE_BITS +: LINE_BITS]);
      end
   endtask

   task automatic test_rdw();
      logic [QW-1:0] e;
      logic [LINE_BITS-1:0] d;
      int w;
      d = {8{32'hDEAD_BEEF}};
      bus.wren = 1'b1; bus.wrway = 4'b0011; bus.wraddress = 8'd9; bus.data = d;
      bus.byteena = '1; bus.rden = 1'b1; bus.rdaddress = 8'd9;
      tick();
      idle();
      e = exp_q();
      vectors++;
      if (bus.q[0 +: LINE_BITS] !== d || bus.q[LINE_BITS +: LINE_BITS] !== d) begin
         miscompares++;
         $display("FAIL rdw_fwd way0=%h way1=%h expected=%h", bus.q[0 +: LINE_BITS],
                  bus.q[LINE_BITS +: LINE_BITS], d);
      end
      vectors++;
      if (bus.q !== e) begin
         miscompares++; w = bad_way(bus.q, e);
         $display("FAIL rdw_all way %0d q=%h expected=%h", w,
                  bus.q[w*LINE_BITS +: LINE_BITS], e[w*LINE_BITS +: LINE_BITS]);
      end
   endtask

   task automatic test_held_coherence();
      logic [QW-1:0] e, saved;
      int w;
      bus.rden = 1'b1; bus.rdaddress = 8'd12;
      tick();
      idle();
      bus.wren = 1'b1; bus.wrway = 4'b0001; bus.wraddress = 8'd12;
      bus.data = rand_line(); bus.data[7:0] = 8'h7E; bus.byteena = 32'h1;
      tick();
      idle();
      e = exp_q();
      vectors++;
      if (bus.q[7:0] !== 8'h7E) begin
         miscompares++; $display("FAIL held_byte0 q=%h expected=7e", bus.q[7:0]);
      end
      vectors++;
      if (bus.q !== e) begin
         miscompares++; w = bad_way(bus.q, e);
         $display("FAIL held_update way %0d q=%h expected=%h", w,
                  bus.q[w*LINE_BITS +: LINE_BITS], e[w*LINE_BITS +: LINE_BITS]);
      end
      saved = e;
      bus.wren = 1'b1; bus.wrway = '1; bus.wraddress = 8'd13;
      bus.data = rand_line(); bus.byteena = '1;
      tick();
      idle();
      vectors++;
      if (bus.q !== saved) begin
         miscompares++; w = bad_way(bus.q, saved);
         $display("FAIL other_set_write way %0d q=%h expected=%h", w,
                  bus.q[w*LINE_BITS +: LINE_BITS], saved[w*LINE_BITS +: LINE_BITS]);
      end
   endtask

   task automatic test_back_to_back();
      logic [QW-1:0] e;
      int w;
      for (int i = 0; i < 4; i++) begin
         bus.rden = 1'b1; bus.rdaddress = 8'd20;
         bus.wren = (i != 3); bus.wraddress = 8'd20; bus.wrway = 4'($urandom);
         bus.byteena = $urandom; bus.data = rand_line();
         tick();
         e = exp_q();
         vectors++;
         if (bus.q !== e) begin
            miscompares++; w = bad_way(bus.q, e);
            $display("FAIL b2b_%0d way %0d q=%h expected=%h", i, w,
                     bus.q[w*LINE_BITS +: LINE_BITS], e[w*LINE_BITS +: LINE_BITS]);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      logic [QW-1:0] e;
      int w;
      bus.rden = 1'b1; bus.rdaddress = 8'd3;
      tick();
      idle();
      rst_n = 1'b0;
      tick();
      vectors++;
      if (bus.ready !== 1'b0 || bus.q !== '0) begin
         miscompares++; $display("FAIL midreset ready=%b q_nonzero=%b expected 0/0",
                                 bus.ready, |bus.q);
      end
      rst_n = 1'b1;
`ifdef DCACHE_DATA_CLEAR_EN
      // Abort the sweep at set 100 and check a full sweep follows.
      for (int i = 0; i < 100; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < SETS + 1; i++) begin
         tick();
         vectors++;
         if (bus.ready !== rdy_m || bus.q !== '0) begin
            miscompares++;
            $display("FAIL sweep_restart cycle %0d ready=%b expected=%b q_nonzero=%b",
                     i + 1, bus.ready, rdy_m, |bus.q);
         end
      end
`else
      tick();
      vectors++;
      if (bus.ready !== 1'b1) begin
         miscompares++; $display("FAIL ready_after_reset ready=%b expected=1", bus.ready);
      end
`endif
      bus.rden = 1'b1; bus.rdaddress = 8'd3;
      tick();
      idle();
      e = exp_q();
      vectors++;
      if (bus.q !== e) begin
         miscompares++; w = bad_way(bus.q, e);
         $display("FAIL post_reset_read way %0d q=%h expected=%h", w,
                  bus.q[w*LINE_BITS +: LINE_BITS], e[w*LINE_BITS +: LINE_BITS]);
      end
   endtask

   task automatic test_random();
      logic [QW-1:0] e;
      int w;
      for (int i = 0; i < 10000; i++) begin
         bus.rden = ($urandom_range(0, 2) == 0);
         bus.rdaddress = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         bus.wren = ($urandom_range(0, 1) == 0);
         bus.wraddress = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         bus.wrway = 4'($urandom);
         case ($urandom_range(0, 5))
            0: bus.byteena = '0;
            1: bus.byteena = '1;
            default: bus.byteena = $urandom;
         endcase
         bus.data = rand_line();
         tick();
         e = exp_q();
         vectors++;
         if (bus.q !== e) begin
            miscompares++; w = bad_way(bus.q, e);
            $display("FAIL random_%0d way %0d q=%h expected=%h", i, w,
                     bus.q[w*LINE_BITS +: LINE_BITS], e[w*LINE_BITS +: LINE_BITS]);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_write_read();
      test_rdw();
      test_held_coherence();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dcache_data_array.md
# dcache_data_array

Multi-way successor to the single-way D-cache data store. Holds `WAYS` parallel arrays of `2**INDEX_BITS` cache lines and performs byte-enabled writes to any subset of ways. It returns all ways of the addressed set one cycle after a read. The returned lines stay coherent with writes, both same-cycle read-during-write and later writes to the held set. It sits between the D-cache controller (tag compare / way select) and the block RAMs. It also provides an optional zero-clear sweep after reset.

## Interface
Parameters:
- `WAYS`, 2, number of ways (1..8)
- `INDEX_BITS`, 8, set index width
- `OFFSET_BITS`, 5, byte offset width
- Derived: `BYTES = 2**OFFSET_BITS`, `LINE_BITS = 8*BYTES`, `SETS = 2**INDEX_BITS`

Ports:
- `clock` in 1: single clock, all logic on rising edge
- `reset_n` in 1: synchronous, active-low reset
- `ready` out 1: array accepts reads/writes
- `rden` in 1: read request
- `rdaddress` in `INDEX_BITS`: read set index
- `q` out `WAYS*LINE_BITS`: way *w* at bits `[w*LINE_BITS +: LINE_BITS]`
- `wren` in 1: write request
- `wrway` in `WAYS`: way select, any subset
- `wraddress` in `INDEX_BITS`: write set index
- `data` in `LINE_BITS`: write line, same data to every selected way
- `byteena` in `BYTES`: per-byte write enable

## Operation
- Reset (`reset_n`=0 at an edge): `ready`=0, `q`=0, the held-address register clears, and the held-valid flag clears. RAM contents are not touched by reset itself.
- While `ready`=0, `rden`/`wren` are ignored and `q` holds its value.
- Write: if `wren & ready`, the following bytes commit at the edge: every byte *b* with `byteena[b]` in every way *w* with `wrway[w]`, at set `wraddress`. `wren` with `wrway`=0 or `byteena`=0 is a no-op.
- Read: if `rden & ready`, set `rdaddress` is latched as the held address and `q` presents all ways of that set after the edge. Held-valid becomes 1.
- `q` is forced to 0 until held-valid=1.
- Read-during-write, same set, same cycle: write-first. `q` shows the merged new bytes for the written ways and the old bytes elsewhere.
- Held-set coherence: with `rden`=0, a write to the held address updates `q` for the written bytes/ways after the edge. A plain BRAM would return stale data here. Implement with a per-way registered bypass mask plus data, or by re-issuing the read of the held address.
- Back-to-back same-set reads return the latest data, including writes from the previous cycle.

## Timing
- Read latency is 1: request sampled at edge N, `q` valid from after edge N until the next accepted read or held-set write.
- Write latency is 1: data written at edge N is visible to a read sampled at edge N (forwarded) and at any later edge.
- No backpressure. `ready` is the only flow control and is constant 1 after init.
- `reset_n` low mid-operation or mid-sweep aborts the operation next edge. The sweep restarts from set 0.

## Configuration
- `DCACHE_DATA_CLEAR_EN` defined: after reset, a two-state FSM runs.
  - CLEAR writes all-zero lines to every way, one set per cycle, sets 0..`SETS`-1 (`SETS` cycles).
  - READY is entered the edge after set `SETS`-1 is written; `ready`=1 from then on.
  - The clear counter is `INDEX_BITS` wide and stops at `SETS`-1 (no wrap).
- Not defined: no FSM. `ready`=1 after the first edge with `reset_n`=1. RAM contents are undefined until written.

## Structure
- Package `dcache_pkg`:
  - `OFFSET_BITS`/`INDEX_BITS` defaults
  - line typedef `dcache_line_t` (`LINE_BITS`)
  - byte-mask typedef
  - FSM state enum `{CLEAR, READY}`
- One `generic_data_bram` instance per way via generate, with a 1-cycle read and byte-enabled write.
- Forwarding/coherence logic lives in this module; no further sub-module.

## Test plan
- Reset with the macro on, `SETS`=256: `ready`=0 for 256 cycles, then 1; reading set 37 returns all-zero lines in every way.
- Write way 1, set 5, `data`=0x…A5A5, `byteena`=0x0000000F; read set 5 next cycle. Way 1 bytes 0-3 = A5, others unchanged; way 0 untouched.
- Same-cycle read and write of set 9, `wrway`=2'b11, `byteena`=all ones, `data`=0xDEAD…: `q` for both ways = 0xDEAD… after one edge.
- Read set 12, then idle `rden`=0 and write set 12 way 0 byte 0 = 0x7E: `q` way 0 byte 0 becomes 0x7E next cycle with no new read. A write to set 13 leaves `q` unchanged.
- Assert `reset_n`=0 at clear-set 100, release: `ready` stays 0 for a full 256-cycle sweep; `q`=0 throughout.
- Random reads/writes against a behavioural byte-array model for 10k cycles, `WAYS`=4: zero `q` mismatches.
